reg_cmd_ctrl: RTL and testbench

Byte-stream command controller that sequences the register bank in front of it. It parses framed read/write commands from a host byte link (UART/SPI receiver side), drives the bank's one-hot `valid_bus` / `rdreq_bus` strobes with `master_data`, captures `slave_data_bus` on reads, and returns an acknowledge or response frame over a ready/valid transmit link. It also detects malformed or stalled frames and counts them.

---
 rtl/reg_cmd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_reg_cmd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: byte-stream command controller for an N-channel register bank.
//
// Parses framed host commands (0xAA, {rw,addr[6:0]}, [wdata]) from rx_data/rx_valid,
// pulses one bit of valid_bus (write) or rdreq_bus (read) for one cycle, and returns
// an ack/response frame on the tx ready/valid link.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_data/rx_valid  received byte + one-cycle strobe (no backpressure)
//   tx_data/tx_valid  response byte, held until tx_ready
//   tx_ready          transmitter accepts on tx_valid & tx_ready
//   master_data       write data to the bank, holds between writes
//   valid_bus         one-hot write strobe
//   rdreq_bus         one-hot read strobe
//   slave_data_bus    bank read data, byte i at [i*8+:8]
//   busy              high whenever the controller is not idle
//   err_cnt           saturating count of bad-address, dropped-byte and timeout events

// Per-channel address decode and read-data gating.
module reg_cmd_chan #(
  parameter int IDX = 0
) (
  input  logic [6:0] addr,
  input  logic [7:0] din,
  output logic       hit,
  output logic [7:0] dout
);
  assign hit  = (addr == 7'(IDX));
  assign dout = hit ? din : 8'h00;
endmodule

module reg_cmd_ctrl #(
  parameter int N       = 27,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [7:0]     master_data,
  output logic [N-1:0]   valid_bus,
  output logic [N-1:0]   rdreq_bus,
  input  logic [N*8-1:0] slave_data_bus,
  output logic           busy,
  output logic [7:0]     err_cnt
);

  localparam int             CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT - 1);
  localparam logic [7:0]     HDR    = 8'hAA;
  localparam logic [7:0]     ACK    = 8'h55;
  localparam logic [7:0]     NAK    = 8'hEE;

  typedef enum logic [2:0] {IDLE, CMD, WDATA, WSTB, RSTB, TX0, TX1, TX2} state_t;

  // Bytes after the first one of a response frame.
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] rdata;
    logic       len3;
  } resp_t;

  state_t              state;
  resp_t               resp;
  logic [CW-1:0]       idle_cnt;
  logic [6:0]          dec_addr;
  logic [N-1:0]        hit;
  logic [N-1:0][7:0]   chan_dout;
  logic [7:0]          rd_sel;
  logic                addr_bad;
  logic                err_ev;

  assign busy = (state != IDLE);

  // The command byte is decoded straight off rx_data so the read strobe can be
  // registered on the same edge the command is accepted; later states use the latched cmd.
  assign dec_addr = (state == CMD) ? rx_data[6:0] : resp.cmd[6:0];
  assign addr_bad = ({1'b0, rx_data[6:0]} >= 8'(N));

  for (genvar i = 0; i < N; i++) begin : g_chan
    reg_cmd_chan #(.IDX(i)) u_chan (
      .addr (dec_addr),
      .din  (slave_data_bus[i*8 +: 8]),
      .hit  (hit[i]),
      .dout (chan_dout[i])
    );
  end

  always_comb begin
    rd_sel = 8'h00;
    for (int i = 0; i < N; i++) rd_sel = rd_sel | chan_dout[i];
  end

  // All error sources OR together so simultaneous events count once.
  always_comb begin
    err_ev = 1'b0;
    case (state)
      WSTB, RSTB, TX0, TX1, TX2: err_ev = rx_valid;
      CMD:   err_ev = rx_valid ? addr_bad : (idle_cnt == TO_MAX);
      WDATA: err_ev = !rx_valid && (idle_cnt == TO_MAX);
      default: err_ev = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      resp        <= '0;
      idle_cnt    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      master_data <= 8'h00;
      valid_bus   <= '0;
      rdreq_bus   <= '0;
      err_cnt     <= 8'h00;
    end else begin
      // Strobes are single-cycle pulses.
      valid_bus <= '0;
      rdreq_bus <= '0;
      if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;

      case (state)
        IDLE: begin
          if (rx_valid && rx_data == HDR) begin
            state    <= CMD;
            idle_cnt <= '0;
          end
        end

        CMD, WDATA: begin
          if (rx_valid) begin
            idle_cnt <= '0;
            if (state == CMD) begin
              resp.cmd <= rx_data;
              if (addr_bad) begin
                resp.len3 <= 1'b0;
                tx_valid  <= 1'b1;
                tx_data   <= NAK;
                state     <= TX0;
              end else if (rx_data[7]) begin
                rdreq_bus <= hit;
                state     <= RSTB;
              end else begin
                state <= WDATA;
              end
            end else begin
              master_data <= rx_data;
              valid_bus   <= hit;
              state       <= WSTB;
            end
          end else if (idle_cnt == TO_MAX) begin
            idle_cnt <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        WSTB: begin
          resp.len3 <= 1'b0;
          tx_valid  <= 1'b1;
          tx_data   <= ACK;
          state     <= TX0;
        end

        RSTB: begin
          // Bank data is combinational from rdreq, which is high this cycle.
          resp.rdata <= rd_sel;
          resp.len3  <= 1'b1;
          tx_valid   <= 1'b1;
          tx_data    <= ACK;
          state      <= TX0;
        end

        TX0: begin
          if (tx_ready) begin
            tx_data <= resp.cmd;
            state   <= TX1;
          end
        end

        TX1: begin
          if (tx_ready) begin
            if (resp.len3) begin
              tx_data <= resp.rdata;
              state   <= TX2;
            end else begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              state    <= IDLE;
            end
          end
        end

        TX2: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb_reg_cmd_ctrl: randomized + directed bench for reg_cmd_ctrl against a
// frame-level reference model (expected response queue, strobe counts, error count).
module tb_reg_cmd_ctrl;
  localparam int N  = 27;
  localparam int TO = 1000;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [7:0]     master_data;
  logic [N-1:0]   valid_bus;
  logic [N-1:0]   rdreq_bus;
  logic [N*8-1:0] slave_data_bus;
  logic           busy;
  logic [7:0]     err_cnt;

  logic [7:0] bank [N];

  for (genvar i = 0; i < N; i++) begin : g_bank
    assign slave_data_bus[i*8 +: 8] = bank[i];
  end

  reg_cmd_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .master_data    (master_data),
    .valid_bus      (valid_bus),
    .rdreq_bus      (rdreq_bus),
    .slave_data_bus (slave_data_bus),
    .busy           (busy),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int         exp_err = 0;
  logic [7:0] exp_md  = 8'h00;
  logic [7:0] expq[$];

  function automatic void err_inc();
    if (exp_err < 255) exp_err++;
  endfunction

  // Monitor: collects accepted tx bytes and strobe activity, tracks invariants.
  logic [7:0]   txq[$];
  int           wr_n = 0, rd_n = 0, viol = 0;
  logic [N-1:0] wr_vec, rd_vec;
  logic [7:0]   wr_md;
  logic         stall_q = 1'b0;
  logic [7:0]   stall_d = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (|valid_bus) begin wr_n++; wr_vec = valid_bus; wr_md = master_data; end
      if (|rdreq_bus) begin rd_n++; rd_vec = rdreq_bus; end
      if ((|valid_bus && |rdreq_bus) || !$onehot0(valid_bus) || !$onehot0(rdreq_bus)) viol++;
      if (!rst && stall_q && (!tx_valid || tx_data != stall_d)) viol++;
      stall_q = !rst && tx_valid && !tx_ready;
      stall_d = tx_data;
    end
  end

  // tx_ready: 0 = always ready, 1 = random, 2 = never ready
  int rdy_mode = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] onehot(input int a);
    logic [N-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return 32'(v);
  endfunction

  // Wait for the expected response, then check bytes, strobes and counters.
  task automatic finish(input string tag, input int ewn, input int ern, input int a);
    int k;
    for (k = 0; k < 400 && (txq.size() < expq.size() || busy); k++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_len"}, txq.size(), expq.size());
    foreach (expq[i])
      chk({tag, "_byte"}, (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
    chk({tag, "_wr_n"}, wr_n, ewn);
    chk({tag, "_rd_n"}, rd_n, ern);
    if (ewn > 0) begin
      chk({tag, "_wr_vec"}, 32'(wr_vec), onehot(a));
      chk({tag, "_wr_md"}, wr_md, exp_md);
    end
    if (ern > 0) chk({tag, "_rd_vec"}, 32'(rd_vec), onehot(a));
    chk({tag, "_md"}, master_data, exp_md);
    chk({tag, "_err"}, err_cnt, exp_err);
    chk({tag, "_busy"}, busy, 0);
    txq.delete();
    expq.delete();
    wr_n = 0;
    rd_n = 0;
  endtask

  task automatic run_frame(input int kind, input int a, input logic [7:0] d, input logic rw);
    logic [7:0] cmd;
    wr_n = 0;
    rd_n = 0;
    txq.delete();
    case (kind)
      0: begin
        cmd = {1'b0, 7'(a)};
        exp_md = d;
        expq = '{8'h55, cmd};
        send(8'hAA); send(cmd); send(d);
        finish("wr", 1, 0, a);
      end
      1: begin
        cmd = {1'b1, 7'(a)};
        expq = '{8'h55, cmd, bank[a]};
        send(8'hAA); send(cmd);
        finish("rd", 0, 1, a);
      end
      default: begin
        cmd = {rw, 7'(a)};
        err_inc();
        expq = '{8'hEE, cmd};
        send(8'hAA); send(cmd);
        finish("badaddr", 0, 0, 0);
      end
    endcase
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int i = 0; i < N; i++) bank[i] = 8'($urandom);
    bank[11] = 8'h7F;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_md", master_data, 0);
    chk("rst_vb", 32'(valid_bus), 0);
    chk("rst_rb", 32'(rdreq_bus), 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;

    // Directed write with strobe timing
    send(8'hAA); send(8'h05); send(8'h01);
    @(negedge clk);
    chk("w_strobe", 32'(valid_bus), 32'h20);
    chk("w_strobe_md", master_data, 8'h01);
    @(negedge clk);
    chk("w_strobe_off", 32'(valid_bus), 0);
    chk("w_txv", tx_valid, 1);
    chk("w_tx0", tx_data, 8'h55);
    exp_md = 8'h01;
    expq = '{8'h55, 8'h05};
    finish("dwr", 1, 0, 5);

    // Directed read with strobe timing
    send(8'hAA); send(8'h8B);
    @(negedge clk);
    chk("r_strobe", 32'(rdreq_bus), onehot(11));
    chk("r_no_wr", 32'(valid_bus), 0);
    @(negedge clk);
    chk("r_strobe_off", 32'(rdreq_bus), 0);
    chk("r_txv", tx_valid, 1);
    chk("r_tx0", tx_data, 8'h55);
    expq = '{8'h55, 8'h8B, 8'h7F};
    finish("drd", 0, 1, 11);

    // Bad address (addr == N)
    run_frame(2, 27, 8'h00, 1'b0);

    // Backpressure with a dropped byte
    rdy_mode = 2;
    send(8'hAA); send(8'h8B);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_txv", tx_valid, 1);
      chk("bp_tx0", tx_data, 8'h55);
      if (i == 4) begin
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        err_inc();
      end
    end
    rdy_mode = 0;
    expq = '{8'h55, 8'h8B, 8'h7F};
    finish("bp", 0, 1, 11);

    // Timeout after header, then a normal write
    send(8'hAA);
    repeat (TO - 3) @(negedge clk);
    chk("to_busy_before", busy, 1);
    repeat (5) @(negedge clk);
    err_inc();
    chk("to_busy_after", busy, 0);
    chk("to_err", err_cnt, exp_err);
    chk("to_no_tx", txq.size(), 0);
    run_frame(0, 3, 8'hC3, 1'b0);

    // Randomized traffic with random tx_ready
    rdy_mode = 1;
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 2) run_frame(2, $urandom_range(N, 127), 8'h00, 1'($urandom_range(0, 1)));
      else           run_frame(kind, $urandom_range(0, N - 1), 8'($urandom), 1'b0);
    end
    rdy_mode = 0;

    // Saturate err_cnt with dropped bytes while stalled in TX0
    rdy_mode = 2;
    send(8'hAA); send(8'h81);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 260; i++) begin
      send(8'($urandom));
      err_inc();
    end
    @(negedge clk);
    chk("sat_err", err_cnt, 255);
    rdy_mode = 0;
    expq = '{8'h55, 8'h81, bank[1]};
    finish("sat", 0, 1, 1);

    // Reset during TX1 of a read
    send(8'hAA); send(8'h8B);
    repeat (3) @(negedge clk);
    chk("tx1_valid", tx_valid, 1);
    chk("tx1_data", tx_data, 8'h8B);
    rst = 1'b1;
    #1;
    exp_err = 0;
    exp_md  = 8'h00;
    chk("mid_rst_txv", tx_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rb", 32'(rdreq_bus), 0);
    chk("mid_rst_err", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    txq.delete();
    send(8'h13);
    repeat (5) @(negedge clk);
    #1;
    chk("garbage_busy", busy, 0);
    chk("garbage_err", err_cnt, exp_err);
    chk("garbage_tx", txq.size(), 0);
    chk("garbage_md", master_data, exp_md);

    chk("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
